frame_sequencer: RTL and testbench

Upstream feeder for the board renderer. It generates 640x480@60 VGA timing and the pixel coordinates x/y. It double-buffers the game-logic board (grid plus new-tile mask) so the display only changes during vertical blanking, which prevents tearing. It also runs the per-frame fade countdown (new_tiles_counter) for freshly spawned tiles. Outputs connect directly to the renderer's grid, new_tiles, new_tiles_counter, x and y inputs.

---
 rtl/frame_pkg.sv | 38 +++
 rtl/frame_sequencer_if.sv | 15 +
 rtl/frame_sequencer_vga_timing.sv | 53 +++++
 rtl/frame_sequencer.sv | 95 +++++++++
 tb/tb_frame_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// Shared constants and board types for the frame sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_pkg;

  // Default 640x480@60 timing
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int COORD_BITS = 10;

  // Board geometry: 16 cells of 4-bit exponent
  localparam int CELL_BITS = 4;
  localparam int NUM_CELLS = 16;
  localparam int GRID_BITS = CELL_BITS * NUM_CELLS;

  typedef logic [GRID_BITS-1:0] grid_t;
  typedef logic [NUM_CELLS-1:0] mask_t;

  typedef struct packed {
    grid_t grid;
    mask_t new_tiles;
  } board_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Board update channel from game logic into the frame sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; payload held stable while valid && !ready.
interface frame_sequencer_if;
  import frame_pkg::*;

  grid_t upd_grid;
  mask_t upd_new_tiles;
  logic  upd_valid;
  logic  upd_ready;

  modport master (output upd_grid, output upd_new_tiles, output upd_valid, input upd_ready);
  modport slave  (input upd_grid, input upd_new_tiles, input upd_valid, output upd_ready);

endinterface

// File: rtl/frame_sequencer_vga_timing.sv
// VGA raster counters with sync/blank decode.
// Latency: decodes are combinational from registered x/y (aligned with x/y).
// Backpressure: none, free-running.
module vga_timing #(
  parameter int H_ACTIVE = frame_pkg::H_ACTIVE,
  parameter int H_FP     = frame_pkg::H_FP,
  parameter int H_SYNC   = frame_pkg::H_SYNC,
  parameter int H_BP     = frame_pkg::H_BP,
  parameter int V_ACTIVE = frame_pkg::V_ACTIVE,
  parameter int V_FP     = frame_pkg::V_FP,
  parameter int V_SYNC   = frame_pkg::V_SYNC,
  parameter int V_BP     = frame_pkg::V_BP
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [frame_pkg::COORD_BITS-1:0] x,
  output logic [frame_pkg::COORD_BITS-1:0] y,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             display_on,
  output logic                             vblank_start
);
  import frame_pkg::*;

  localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO       = H_ACTIVE + H_FP;
  localparam int HS_HI       = HS_LO + H_SYNC;
  localparam int VS_LO       = V_ACTIVE + V_FP;
  localparam int VS_HI       = VS_LO + V_SYNC;

  // Raster scan: x every clock, y on x wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x == COORD_BITS'(LINE_LEN - 1)) begin
      x <= '0;
      y <= (y == COORD_BITS'(FRAME_LINES - 1)) ? '0 : y + COORD_BITS'(1);
    end else begin
      x <= x + COORD_BITS'(1);
    end
  end

  // Sync and blanking decode straight off the counters
  always_comb begin
    hsync        = !((x >= COORD_BITS'(HS_LO)) && (x < COORD_BITS'(HS_HI)));
    vsync        = !((y >= COORD_BITS'(VS_LO)) && (y < COORD_BITS'(VS_HI)));
    display_on   = (x < COORD_BITS'(H_ACTIVE)) && (y < COORD_BITS'(V_ACTIVE));
    vblank_start = (x == '0) && (y == COORD_BITS'(V_ACTIVE));
  end

endmodule

// File: rtl/frame_sequencer.sv
// VGA timing plus vblank-synchronous board double buffer and new-tile fade counter.
// Latency: accepted update is displayed after the next vblank_start edge (never bypassed).
// Backpressure: one-deep pending slot; upd_ready low while full except on the commit cycle.
module frame_sequencer #(
  parameter int H_ACTIVE        = frame_pkg::H_ACTIVE,
  parameter int H_FP            = frame_pkg::H_FP,
  parameter int H_SYNC          = frame_pkg::H_SYNC,
  parameter int H_BP            = frame_pkg::H_BP,
  parameter int V_ACTIVE        = frame_pkg::V_ACTIVE,
  parameter int V_FP            = frame_pkg::V_FP,
  parameter int V_SYNC          = frame_pkg::V_SYNC,
  parameter int V_BP            = frame_pkg::V_BP,
  parameter int FADE_START      = 7,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  frame_sequencer_if.slave                 upd,
  output logic [frame_pkg::COORD_BITS-1:0] x,
  output logic [frame_pkg::COORD_BITS-1:0] y,
  output logic                             hsync,
  output logic                             vsync,
  output logic                             display_on,
  output logic                             vblank_start,
  output logic [frame_pkg::GRID_BITS-1:0]  grid,
  output logic [frame_pkg::NUM_CELLS-1:0]  new_tiles,
  output logic [2:0]                       new_tiles_counter
);
  import frame_pkg::*;

  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  board_t             pend;
  logic               full;
  logic               commit;
  logic               accept;
  logic [DIV_W-1:0]   fade_div;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .hsync        (hsync),
    .vsync        (vsync),
    .display_on   (display_on),
    .vblank_start (vblank_start)
  );

  // Commit frees the slot in the same cycle, so a waiting update can refill it
  always_comb begin
    commit        = vblank_start && full;
    upd.upd_ready = !full || commit;
    accept        = upd.upd_valid && upd.upd_ready;
  end

  // Pending slot: one buffered board waiting for the next vblank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      full <= 1'b0;
    end else if (accept) begin
      pend <= '{grid: upd.upd_grid, new_tiles: upd.upd_new_tiles};
      full <= 1'b1;
    end else if (commit) begin
      full <= 1'b0;
    end
  end

  // Displayed board and fade countdown, only touched on the vblank_start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grid              <= '0;
      new_tiles         <= '0;
      new_tiles_counter <= '0;
      fade_div          <= '0;
    end else if (commit) begin
      grid              <= pend.grid;
      new_tiles         <= pend.new_tiles;
      new_tiles_counter <= (|pend.new_tiles) ? 3'(FADE_START) : 3'd0;
      fade_div          <= '0;
    end else if (vblank_start && (new_tiles_counter != 3'd0)) begin
      if (fade_div == DIV_W'(FRAMES_PER_STEP - 1)) begin
        fade_div          <= '0;
        new_tiles_counter <= new_tiles_counter - 3'd1;
      end else begin
        fade_div <= fade_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_frame_sequencer;
  import frame_pkg::*;

  // Shrunken raster so many frames fit in a short run
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FS = 7, FPS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  x, y;
  logic        hsync, vsync, display_on, vblank_start;
  logic [63:0] grid;
  logic [15:0] new_tiles;
  logic [2:0]  new_tiles_counter;

  always #5 clk = ~clk;

  frame_sequencer_if u_if();

  frame_sequencer #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .FADE_START (FS), .FRAMES_PER_STEP (FPS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .upd               (u_if),
    .x                 (x),
    .y                 (y),
    .hsync             (hsync),
    .vsync             (vsync),
    .display_on        (display_on),
    .vblank_start      (vblank_start),
    .grid              (grid),
    .new_tiles         (new_tiles),
    .new_tiles_counter (new_tiles_counter)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state: time since reset, displayed board, fade origin, pending slot
  typedef struct {
    logic [63:0] g;
    logic [15:0] m;
  } upd_t;

  upd_t        offerq[$];
  int          t;
  logic [63:0] m_grid;
  logic [15:0] m_mask;
  int          m_base;
  int          m_frames;
  logic        m_full;
  upd_t        m_pend;
  int          disp_cnt, vb_cnt, hs_low, vs_low;

  function automatic bit model_vb();
    return ((t % HT) == 0) && (((t / HT) % VT) == VA);
  endfunction

  function automatic int model_cnt();
    int c;
    c = m_base - (m_frames / FPS);
    return (c < 0) ? 0 : c;
  endfunction

  task automatic offer(input logic [63:0] g, input logic [15:0] m);
    upd_t u;
    u.g = g;
    u.m = m;
    offerq.push_back(u);
  endtask

  // One clock: drive, compare against model, advance model, step to next edge
  task automatic cycle();
    int   mx, my;
    bit   vb, exp_rdy, acc, com;
    mx = t % HT;
    my = (t / HT) % VT;
    vb = model_vb();
    if (offerq.size() > 0) begin
      u_if.upd_valid     = 1'b1;
      u_if.upd_grid      = offerq[0].g;
      u_if.upd_new_tiles = offerq[0].m;
    end else begin
      u_if.upd_valid     = 1'b0;
      u_if.upd_grid      = {$urandom, $urandom};
      u_if.upd_new_tiles = 16'($urandom);
    end
    #1;
    exp_rdy = !m_full || vb;
    chk("x", 64'(x), 64'(mx));
    chk("y", 64'(y), 64'(my));
    chk("hsync", 64'(hsync), 64'(!(mx >= HA + HF && mx < HA + HF + HS)));
    chk("vsync", 64'(vsync), 64'(!(my >= VA + VF && my < VA + VF + VS)));
    chk("display_on", 64'(display_on), 64'(mx < HA && my < VA));
    chk("vblank_start", 64'(vblank_start), 64'(vb));
    chk("upd_ready", 64'(u_if.upd_ready), 64'(exp_rdy));
    chk("grid", grid, m_grid);
    chk("new_tiles", 64'(new_tiles), 64'(m_mask));
    chk("counter", 64'(new_tiles_counter), 64'(model_cnt()));

    acc = u_if.upd_valid && exp_rdy;
    com = vb && m_full;
    if (com) begin
      m_grid   = m_pend.g;
      m_mask   = m_pend.m;
      m_base   = (m_pend.m != 0) ? FS : 0;
      m_frames = 0;
    end else if (vb) begin
      m_frames++;
    end
    if (acc) begin
      m_pend = offerq.pop_front();
      m_full = 1'b1;
    end else if (com) begin
      m_full = 1'b0;
    end

    if (display_on)   disp_cnt++;
    if (vblank_start) vb_cnt++;
    if (!hsync)       hs_low++;
    if (!vsync)       vs_low++;
    t++;
    if ((t % (HT * VT)) == 0) begin
      chk("frame_display_on", 64'(disp_cnt), 64'(HA * VA));
      chk("frame_vblank", 64'(vb_cnt), 64'd1);
      chk("frame_hsync_low", 64'(hs_low), 64'(HS * VT));
      chk("frame_vsync_low", 64'(vs_low), 64'(VS * HT));
      disp_cnt = 0; vb_cnt = 0; hs_low = 0; vs_low = 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Advance until the model sits on a vblank_start cycle (bounded by one frame)
  task automatic run_to_vb();
    for (int i = 0; i < HT * VT; i++) begin
      if (model_vb()) break;
      cycle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_grid", grid, 64'd0);
    chk("rst_new_tiles", 64'(new_tiles), 64'd0);
    chk("rst_counter", 64'(new_tiles_counter), 64'd0);
    chk("rst_ready", 64'(u_if.upd_ready), 64'd1);
    chk("rst_hsync", 64'(hsync), 64'd1);
    chk("rst_vsync", 64'(vsync), 64'd1);
    offerq.delete();
    u_if.upd_valid = 1'b0;
    t = 0; m_grid = '0; m_mask = '0; m_base = 0; m_frames = 0; m_full = 1'b0;
    m_pend.g = '0; m_pend.m = '0;
    disp_cnt = 0; vb_cnt = 0; hs_low = 0; vs_low = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    u_if.upd_valid     = 1'b0;
    u_if.upd_grid      = '0;
    u_if.upd_new_tiles = '0;
    #3;
    do_reset();

    // Single update mid-frame, then watch the full fade
    repeat (HT * 2 + 5) cycle();
    offer(64'h0000_0000_0000_0021, 16'h0001);
    run_to_vb();
    chk("pre_commit_grid", grid, 64'd0);
    cycle();
    chk("commit_grid", grid, 64'h21);
    chk("commit_mask", 64'(new_tiles), 64'h1);
    chk("commit_cnt", 64'(new_tiles_counter), 64'd7);
    repeat (4) begin run_to_vb(); cycle(); end
    chk("fade_4", 64'(new_tiles_counter), 64'd6);
    repeat (24) begin run_to_vb(); cycle(); end
    chk("fade_28", 64'(new_tiles_counter), 64'd0);
    chk("fade_mask_kept", 64'(new_tiles), 64'h1);
    repeat (3) begin run_to_vb(); cycle(); end
    chk("fade_hold", 64'(new_tiles_counter), 64'd0);

    // Back-to-back A then B
    offer(64'hAAAA_5555_1234_0001, 16'h8001);
    offer(64'hBBBB_6666_4321_0002, 16'h0300);
    run_to_vb();
    chk("btb_ready_low", 64'(m_full), 64'd1);
    cycle();
    chk("btb_grid_a", grid, 64'hAAAA_5555_1234_0001);
    run_to_vb();
    cycle();
    chk("btb_grid_b", grid, 64'hBBBB_6666_4321_0002);

    // Zero-mask update while the fade is at 3
    run_to_vb();
    offer(64'h0123_4567_89AB_CDEF, 16'h00F0);
    cycle();
    run_to_vb();
    cycle();
    repeat (16) begin run_to_vb(); cycle(); end
    chk("cnt_before_zero", 64'(new_tiles_counter), 64'd3);
    offer(64'hFEDC_BA98_7654_3210, 16'h0000);
    run_to_vb();
    cycle();
    chk("cnt_after_zero", 64'(new_tiles_counter), 64'd0);
    chk("grid_after_zero", grid, 64'hFEDC_BA98_7654_3210);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      if (offerq.size() == 0 && $urandom_range(0, 99) < 2)
        offer({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
      cycle();
    end

    // Reset mid-frame, then resume
    repeat ($urandom_range(50, 200)) cycle();
    do_reset();
    offer({$urandom, $urandom}, 16'h0010);
    repeat (HT * VT * 2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
